// File: rtl/rally_referee_pkg.sv
// Shared types for the volley-game referee: FSM state encoding, side identifiers
// and the match-end rule.
package referee_pkg;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_RALLY = 2'd1,
        ST_HOLD  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    // True when the side holding `mine` points has won against `theirs`.
    function automatic logic win_check(input int mine, input int theirs,
                                       input int win_score, input int margin,
                                       input int cap);
        return ((mine >= win_score) && (mine >= theirs + margin)) || (mine == cap);
    endfunction

endpackage

// File: rtl/rally_referee_if.sv
// Signal bundle between the collision logic, the referee and the score display.
interface rally_referee_if #(
    parameter int COORD_W = 12,
    parameter int SCORE_W = 5
);
    logic [COORD_W-1:0] xposball;
    logic [COORD_W-1:0] yposball;
    logic               collision_p1;
    logic               collision_p2;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic               server;
    logic [1:0]         state_o;
    logic               point_pulse;
    logic               fault_touch;
    logic               winner;
    logic               endgame;

    modport master (
        output xposball, yposball, collision_p1, collision_p2,
        input  score_p1, score_p2, server, state_o, point_pulse, fault_touch, winner, endgame
    );

    modport slave (
        input  xposball, yposball, collision_p1, collision_p2,
        output score_p1, score_p2, server, state_o, point_pulse, fault_touch, winner, endgame
    );
endinterface

// File: rtl/rally_referee_touch_counter.sv
// Per-player touch counter: edge-detects contact, qualifies it by ball side and
// height, and saturates one past the legal touch limit.
module touch_counter #(
    parameter int MAX_TOUCHES = 3
) (
    input  logic clk_div,
    input  logic rst,
    input  logic collision_i,
    input  logic on_side_i,
    input  logic airborne_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic leave_i,
    output logic touch_o,
    output logic exceeded_o
);
    localparam int CNT_W = $clog2(MAX_TOUCHES + 2);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_TOUCHES + 1);

    logic             col_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign touch_o    = collision_i & ~col_prev_q & on_side_i & airborne_i & en_i;
    assign exceeded_o = (cnt_q == LIMIT);

    // A clear still lets the serve touch load as the first touch of the rally.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = touch_o ? CNT_W'(1) : '0;
        end else if (leave_i) begin
            cnt_d = '0;
        end else if (touch_o && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_div) begin
        if (rst) begin
            col_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            col_prev_q <= collision_i;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: rtl/rally_referee.sv
// Match referee: rally FSM, scoring with margin and cap, serve ownership,
// post-point hold and touch-fault reporting.
module rally_referee
    import referee_pkg::*;
#(
    parameter int COORD_W     = 12,
    parameter int SCORE_W     = 5,
    parameter int WIN_SCORE   = 15,
    parameter int WIN_MARGIN  = 2,
    parameter int SCORE_CAP   = 25,
    parameter int MAX_TOUCHES = 3,
    parameter int NET_X       = 511,
    parameter int GROUND_Y    = 750,
    parameter int HOLD_TICKS  = 100
) (
    input  logic           clk_div,
    input  logic           rst,
    rally_referee_if.slave bus
);
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [COORD_W-1:0] NET_X_V     = COORD_W'(NET_X);
    localparam logic [COORD_W-1:0] GROUND_Y_V  = COORD_W'(GROUND_Y);
    localparam logic [SCORE_W-1:0] SCORE_CAP_V = SCORE_W'(SCORE_CAP);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic [SCORE_W-1:0] score_p2_q, score_p2_d;
    logic               server_q, server_d;
    logic               point_q, point_d;
    logic               fault_q, fault_d;
    logic               winner_q, winner_d;
    logic               endgame_q, endgame_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    logic       side_now, side_q;
    logic       ground_now, ground_q;
    logic [1:0] collision;
    logic [1:0] touch;
    logic [1:0] exceeded;
    logic       count_en;
    logic       count_clr;
    logic       award;
    logic       scorer;

    assign side_now   = (bus.xposball < NET_X_V) ? P1 : P2;
    assign ground_now = (bus.yposball >= GROUND_Y_V);
    assign collision  = {bus.collision_p2, bus.collision_p1};
    assign count_en   = (state_q == ST_SERVE) || (state_q == ST_RALLY);
    assign count_clr  = (state_q != ST_RALLY);

    for (genvar gi = 0; gi < 2; gi++) begin : g_touch
        logic on_side;
        logic leave;
        assign on_side = (side_now == 1'(gi));
        assign leave   = (side_q == 1'(gi)) && !on_side;

        touch_counter #(.MAX_TOUCHES(MAX_TOUCHES)) u_touch (
            .clk_div    (clk_div),
            .rst        (rst),
            .collision_i(collision[gi]),
            .on_side_i  (on_side),
            .airborne_i (~ground_now),
            .en_i       (count_en),
            .clr_i      (count_clr),
            .leave_i    (leave),
            .touch_o    (touch[gi]),
            .exceeded_o (exceeded[gi])
        );
    end

    // Ground and side are taken from the previous tick so a landing and a
    // fourth touch seen on the same tick are judged together.
    always_comb begin
        state_d    = state_q;
        score_p1_d = score_p1_q;
        score_p2_d = score_p2_q;
        server_d   = server_q;
        point_d    = 1'b0;
        fault_d    = 1'b0;
        winner_d   = winner_q;
        endgame_d  = endgame_q;
        hold_d     = hold_q;
        award      = 1'b0;
        scorer     = P1;

        case (state_q)
            ST_SERVE: begin
                if (|touch) state_d = ST_RALLY;
            end
            ST_RALLY: begin
                if (ground_q) begin
                    award  = 1'b1;
                    scorer = ~side_q;
                end else if (exceeded[0]) begin
                    award   = 1'b1;
                    scorer  = P2;
                    fault_d = 1'b1;
                end else if (exceeded[1]) begin
                    award   = 1'b1;
                    scorer  = P1;
                    fault_d = 1'b1;
                end
                if (award) begin
                    if (scorer == P1) begin
                        if (score_p1_q != SCORE_CAP_V) score_p1_d = score_p1_q + SCORE_W'(1);
                    end else begin
                        if (score_p2_q != SCORE_CAP_V) score_p2_d = score_p2_q + SCORE_W'(1);
                    end
                    point_d  = 1'b1;
                    server_d = scorer;
                    hold_d   = '0;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    if (win_check(int'(score_p1_q), int'(score_p2_q), WIN_SCORE, WIN_MARGIN, SCORE_CAP)) begin
                        state_d   = ST_OVER;
                        endgame_d = 1'b1;
                        winner_d  = P1;
                    end else if (win_check(int'(score_p2_q), int'(score_p1_q), WIN_SCORE, WIN_MARGIN, SCORE_CAP)) begin
                        state_d   = ST_OVER;
                        endgame_d = 1'b1;
                        winner_d  = P2;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_SERVE;
            end
        endcase
    end

    always_ff @(posedge clk_div) begin
        if (rst) begin
            state_q    <= ST_SERVE;
            score_p1_q <= '0;
            score_p2_q <= '0;
            server_q   <= P1;
            point_q    <= 1'b0;
            fault_q    <= 1'b0;
            winner_q   <= P1;
            endgame_q  <= 1'b0;
            hold_q     <= '0;
            side_q     <= P1;
            ground_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_p1_q <= score_p1_d;
            score_p2_q <= score_p2_d;
            server_q   <= server_d;
            point_q    <= point_d;
            fault_q    <= fault_d;
            winner_q   <= winner_d;
            endgame_q  <= endgame_d;
            hold_q     <= hold_d;
            side_q     <= side_now;
            ground_q   <= ground_now;
        end
    end

    assign bus.score_p1    = score_p1_q;
    assign bus.score_p2    = score_p2_q;
    assign bus.server      = server_q;
    assign bus.state_o     = state_q;
    assign bus.point_pulse = point_q;
    assign bus.fault_touch = fault_q;
    assign bus.winner      = winner_q;
    assign bus.endgame     = endgame_q;
endmodule

// File: tb/tb_rally_referee.sv
// Scoreboard bench for rally_referee: directed match scenarios plus random play
// against a tick-level model of the game rules.
module tb_rally_referee;
    logic clk_div = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_div = ~clk_div;

    rally_referee_if #(.COORD_W(12), .SCORE_W(5)) bus ();

    rally_referee #(
        .COORD_W(12), .SCORE_W(5), .WIN_SCORE(15), .WIN_MARGIN(2), .SCORE_CAP(25),
        .MAX_TOUCHES(3), .NET_X(511), .GROUND_Y(750), .HOLD_TICKS(100)
    ) dut (
        .clk_div(clk_div),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        int edge_no;
        int scorer;
        bit fault;
        int s1;
        int s2;
    } pt_t;

    pt_t exp_q[$];
    pt_t mon_e;

    int n_tests  = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    bit chk_en   = 1'b0;

    // Model of the game: phase 0 serve, 1 rally, 2 hold, 3 over.
    int m_phase, m_server, m_winner, m_hold, m_prev_side, m_last_side;
    int m_touch[2];
    int m_s[2];
    bit m_prev_col[2];
    bit m_last_ground, m_end, m_point, m_fault;

    function automatic bit wins(input int a, input int b);
        return ((a >= 15) && (a - b >= 2)) || (a == 25);
    endfunction

    // Computes what the next clock edge must produce for the given inputs.
    task automatic model_step(input bit r, input int x, input int y, input bit c1, input bit c2);
        bit col[2];
        bit qual[2];
        int side, ph, w;
        bit air, award, f;
        col[0] = c1;
        col[1] = c2;
        m_point = 1'b0;
        m_fault = 1'b0;
        if (r) begin
            m_phase = 0; m_server = 0; m_winner = 0; m_hold = 0; m_end = 1'b0;
            m_prev_side = 0; m_last_side = 0; m_last_ground = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_touch[p] = 0; m_s[p] = 0; m_prev_col[p] = 1'b0;
            end
            return;
        end
        side  = (x < 511) ? 0 : 1;
        air   = (y < 750);
        ph    = m_phase;
        award = 1'b0;
        f     = 1'b0;
        w     = 0;
        for (int p = 0; p < 2; p++)
            qual[p] = col[p] && !m_prev_col[p] && (side == p) && air && (ph <= 1);

        if (ph == 1) begin
            if (m_last_ground) begin
                award = 1'b1; w = 1 - m_last_side;
            end else if (m_touch[0] >= 4) begin
                award = 1'b1; w = 1; f = 1'b1;
            end else if (m_touch[1] >= 4) begin
                award = 1'b1; w = 0; f = 1'b1;
            end
        end else if (ph == 2) begin
            if (m_hold == 1) begin
                if (wins(m_s[0], m_s[1])) begin
                    m_phase = 3; m_end = 1'b1; m_winner = 0;
                end else if (wins(m_s[1], m_s[0])) begin
                    m_phase = 3; m_end = 1'b1; m_winner = 1;
                end else begin
                    m_phase = 0;
                end
            end else begin
                m_hold--;
            end
        end else if (ph == 0 && (qual[0] || qual[1])) begin
            m_phase = 1;
        end

        if (award) begin
            if (m_s[w] < 25) m_s[w]++;
            m_server = w;
            m_point  = 1'b1;
            m_fault  = f;
            m_hold   = 100;
            m_phase  = 2;
            exp_q.push_back('{edge_cnt + 1, w, f, m_s[0], m_s[1]});
        end

        for (int p = 0; p < 2; p++) begin
            if (ph != 1) m_touch[p] = qual[p] ? 1 : 0;
            else if (m_prev_side == p && side != p) m_touch[p] = 0;
            else if (qual[p] && m_touch[p] < 4) m_touch[p]++;
            m_prev_col[p] = col[p];
        end
        m_prev_side   = side;
        m_last_side   = side;
        m_last_ground = !air;
    endtask

    task automatic tick(input bit r, input int x, input int y, input bit c1, input bit c2);
        @(negedge clk_div);
        rst              = r;
        bus.xposball     = 12'(x);
        bus.yposball     = 12'(y);
        bus.collision_p1 = c1;
        bus.collision_p2 = c2;
        model_step(r, x, y, c1, c2);
        chk_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 300, 400, 1'b0, 1'b0);
    endtask

    // The loser touches on his own side, then the ball lands there.
    task automatic play_point(input int p, input int idle_n);
        int l, xl;
        l  = 1 - p;
        xl = (l == 0) ? 200 : 800;
        tick(1'b0, xl, 400, l == 0, l == 1);
        tick(1'b0, xl, 400, 1'b0, 1'b0);
        tick(1'b0, xl, 750, 1'b0, 1'b0);
        idle(idle_n);
    endtask

    task automatic p2_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 800, 400, 1'b0, 1'b1);
            tick(1'b0, 800, 400, 1'b0, 1'b0);
        end
    endtask

    task automatic p1_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 300, 400, 1'b1, 1'b0);
            tick(1'b0, 300, 400, 1'b0, 1'b0);
        end
    endtask

    always @(posedge clk_div) begin
        edge_cnt++;
        #1;
        if (chk_en) begin
            n_tests++;
            if (bus.state_o !== 2'(m_phase) || bus.score_p1 !== 5'(m_s[0]) ||
                bus.score_p2 !== 5'(m_s[1]) || bus.server !== 1'(m_server) ||
                bus.endgame !== m_end || bus.winner !== 1'(m_winner) ||
                bus.point_pulse !== m_point || bus.fault_touch !== m_fault) begin
                n_fail++;
                $display("FAIL outputs edge=%0d got st=%0d sc=%0d:%0d srv=%0d end=%0d win=%0d pp=%0d ft=%0d want st=%0d sc=%0d:%0d srv=%0d end=%0d win=%0d pp=%0d ft=%0d",
                         edge_cnt, bus.state_o, bus.score_p1, bus.score_p2, bus.server,
                         bus.endgame, bus.winner, bus.point_pulse, bus.fault_touch,
                         m_phase, m_s[0], m_s[1], m_server, m_end, m_winner, m_point, m_fault);
            end
            if (bus.point_pulse === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL point_event edge=%0d got an unexpected point, want none", edge_cnt);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.edge_no != edge_cnt || bus.fault_touch !== mon_e.fault ||
                        bus.server !== 1'(mon_e.scorer) || bus.score_p1 !== 5'(mon_e.s1) ||
                        bus.score_p2 !== 5'(mon_e.s2)) begin
                        n_fail++;
                        $display("FAIL point_event got edge=%0d srv=%0d ft=%0d sc=%0d:%0d want edge=%0d srv=%0d ft=%0d sc=%0d:%0d",
                                 edge_cnt, bus.server, bus.fault_touch, bus.score_p1, bus.score_p2,
                                 mon_e.edge_no, mon_e.scorer, mon_e.fault, mon_e.s1, mon_e.s2);
                    end else begin
                        $display("[TB] point edge=%0d to p%0d fault=%0d score %0d:%0d",
                                 edge_cnt, mon_e.scorer + 1, mon_e.fault, mon_e.s1, mon_e.s2);
                    end
                end
            end
        end
    end

    initial begin
        int x, y;
        bit r, c1, c2;
        bus.xposball     = 12'd300;
        bus.yposball     = 12'd400;
        bus.collision_p1 = 1'b0;
        bus.collision_p2 = 1'b0;

        tick(1'b1, 300, 400, 1'b0, 1'b0);
        tick(1'b1, 300, 400, 1'b0, 1'b0);

        // p1 touch, ball lands on side 2
        tick(1'b0, 200, 400, 1'b1, 1'b0);
        tick(1'b0, 200, 400, 1'b0, 1'b0);
        tick(1'b0, 700, 400, 1'b0, 1'b0);
        tick(1'b0, 700, 750, 1'b0, 1'b0);
        idle(110);

        // four p2 touches -> touch fault
        p2_pulses(4);
        idle(110);

        // held contact counts once, then two more touches and a landing
        for (int i = 0; i < 10; i++) tick(1'b0, 800, 400, 1'b0, 1'b1);
        tick(1'b0, 800, 400, 1'b0, 1'b0);
        p2_pulses(2);
        tick(1'b0, 800, 750, 1'b0, 1'b0);
        idle(110);

        // net crossing clears p1's count
        p1_pulses(2);
        tick(1'b0, 600, 400, 1'b0, 1'b0);
        tick(1'b0, 300, 400, 1'b0, 1'b0);
        p1_pulses(2);
        tick(1'b0, 300, 750, 1'b0, 1'b0);
        idle(110);

        // landing together with a fourth touch attempt
        p2_pulses(3);
        tick(1'b0, 800, 750, 1'b0, 1'b1);
        idle(110);

        // fourth touch then landing on the next tick
        p2_pulses(3);
        tick(1'b0, 800, 400, 1'b0, 1'b1);
        tick(1'b0, 800, 750, 1'b0, 1'b0);
        idle(110);

        // reset in the middle of a hold at 7:5
        tick(1'b1, 300, 400, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) play_point(1, 104);
        for (int i = 0; i < 6; i++) play_point(0, 104);
        play_point(0, 20);
        tick(1'b1, 300, 400, 1'b0, 1'b0);
        idle(3);

        // 14:14 then two p1 points
        tick(1'b1, 300, 400, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            play_point(0, 104);
            play_point(1, 104);
        end
        play_point(0, 104);
        play_point(0, 104);
        p1_pulses(2);
        idle(5);

        // 24:24 then the cap decides
        tick(1'b1, 300, 400, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            play_point(0, 104);
            play_point(1, 104);
        end
        play_point(0, 104);
        idle(5);

        // random play
        tick(1'b1, 300, 400, 1'b0, 1'b0);
        for (int k = 0; k < 4000; k++) begin
            r = ((m_phase == 3) && ($urandom_range(0, 15) == 0)) || ($urandom_range(0, 1999) == 0);
            case ($urandom_range(0, 4))
                0: x = 200;
                1: x = 300;
                2: x = 600;
                3: x = 800;
                default: x = int'($urandom_range(0, 1023));
            endcase
            if ($urandom_range(0, 19) == 0) y = int'($urandom_range(750, 1023));
            else y = int'($urandom_range(0, 749));
            c1 = ($urandom_range(0, 2) == 0);
            c2 = ($urandom_range(0, 2) == 0);
            tick(r, x, y, c1, c2);
        end

        @(posedge clk_div);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_points got %0d unawarded points, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
